// File: rtl/rf_read_scoreboard_if.sv
// rf_read_scoreboard_if: decode, register-file, writeback and execute-handoff signals of the register read stage.
interface rf_read_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [AW-1:0]   rs1_i;
    logic [AW-1:0]   rs2_i;
    logic [AW-1:0]   rd_i;
    logic            rd_we_i;
    logic [AW-1:0]   rf_a1_o;
    logic [AW-1:0]   rf_a2_o;
    logic [XLEN-1:0] rf_rd1_i;
    logic [XLEN-1:0] rf_rd2_i;
    logic            wb_valid_i;
    logic [AW-1:0]   wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            retire_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [AW-1:0]   out_rd_o;
    logic            out_rd_we_o;
    modport slave (
        input  in_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, rf_rd1_i, rf_rd2_i,
               wb_valid_i, wb_rd_i, wb_data_i, retire_i, flush_i, out_ready_i,
        output in_ready_o, rf_a1_o, rf_a2_o, out_valid_o, rs1_data_o, rs2_data_o,
               out_rd_o, out_rd_we_o
    );
    modport master (
        output in_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, rf_rd1_i, rf_rd2_i,
               wb_valid_i, wb_rd_i, wb_data_i, retire_i, flush_i, out_ready_i,
        input  in_ready_o, rf_a1_o, rf_a2_o, out_valid_o, rs1_data_o, rs2_data_o,
               out_rd_o, out_rd_we_o
    );
endinterface

// File: rtl/rf_read_scoreboard.sv
// rf_read_scoreboard: operand read with writeback bypass, pending-register hazard stall and a one-entry output register.
module rf_read_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input logic clk,
    input logic rst_n,
    rf_read_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nx;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nx;
    logic [CW:0]     up;
    logic [CW:0]     dn;
    logic            haz;
    logic            ready;
    logic            fire;
    logic            kill;
    logic            out_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_we;
    assign bus.rf_a1_o     = bus.rs1_i;
    assign bus.rf_a2_o     = bus.rs2_i;
    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = out_valid;
    assign bus.rs1_data_o  = rs1_data;
    assign bus.rs2_data_o  = rs2_data;
    assign bus.out_rd_o    = out_rd;
    assign bus.out_rd_we_o = out_rd_we;
    always_comb begin
        haz   = (bus.rs1_i != '0 && pending[bus.rs1_i]) ||
                (bus.rs2_i != '0 && pending[bus.rs2_i]) ||
                (bus.rd_we_i && bus.rd_i != '0 && pending[bus.rd_i]);
        ready = !bus.flush_i && !haz && (!out_valid || bus.out_ready_i) &&
                (inflight < CW'(MAX_INFLIGHT) || bus.retire_i);
        fire  = bus.in_valid_i && ready;
        kill  = bus.flush_i && out_valid && out_rd_we && out_rd != '0;
        op1   = bus.rs1_i == '0 ? '0 :
                (bus.wb_valid_i && bus.wb_rd_i == bus.rs1_i) ? bus.wb_data_i : bus.rf_rd1_i;
        op2   = bus.rs2_i == '0 ? '0 :
                (bus.wb_valid_i && bus.wb_rd_i == bus.rs2_i) ? bus.wb_data_i : bus.rf_rd2_i;
    end
    // Issue set is applied last so it wins over a clear of the same register.
    always_comb begin
        pending_nx = pending;
        if (bus.wb_valid_i) pending_nx[bus.wb_rd_i] = 1'b0;
        if (kill) pending_nx[out_rd] = 1'b0;
        if (fire && bus.rd_we_i) pending_nx[bus.rd_i] = 1'b1;
        pending_nx[0] = 1'b0;
    end
    // A retire with nothing in flight is dropped; the result never goes below zero.
    always_comb begin
        up          = {1'b0, inflight} + (CW+1)'(fire);
        dn          = (CW+1)'(bus.retire_i && inflight != '0) + (CW+1)'(kill);
        inflight_nx = up > dn ? CW'(up - dn) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            inflight  <= '0;
            out_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else begin
            pending  <= pending_nx;
            inflight <= inflight_nx;
            if (bus.flush_i) begin
                out_valid <= 1'b0;
            end else if (fire) begin
                out_valid <= 1'b1;
                rs1_data  <= op1;
                rs2_data  <= op2;
                out_rd    <= bus.rd_i;
                out_rd_we <= bus.rd_we_i;
            end else if (bus.out_ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_read_scoreboard.sv
// tb_rf_read_scoreboard: directed vectors against hand-computed operand, stall and scoreboard values.
module tb_rf_read_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    rf_read_scoreboard_if #(.XLEN(32), .NREG(32)) bus ();
    rf_read_scoreboard #(.XLEN(32), .NREG(32), .MAX_INFLIGHT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.in_valid_i  = 0;
        bus.rs1_i       = 0;
        bus.rs2_i       = 0;
        bus.rd_i        = 0;
        bus.rd_we_i     = 0;
        bus.rf_rd1_i    = 0;
        bus.rf_rd2_i    = 0;
        bus.wb_valid_i  = 0;
        bus.wb_rd_i     = 0;
        bus.wb_data_i   = 0;
        bus.retire_i    = 0;
        bus.flush_i     = 0;
        bus.out_ready_i = 1;
    endtask
    task automatic instr(input int rs1, input int rs2, input int rd, input logic we,
                         input logic [31:0] d1, input logic [31:0] d2);
        bus.in_valid_i = 1;
        bus.rs1_i      = 5'(rs1);
        bus.rs2_i      = 5'(rs2);
        bus.rd_i       = 5'(rd);
        bus.rd_we_i    = we;
        bus.rf_rd1_i   = d1;
        bus.rf_rd2_i   = d2;
    endtask
    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        rst_n = 1;
    endtask
    initial begin
        idle();
        #12;
        check("rst_out_valid", 64'(bus.out_valid_o), 0);
        check("rst_rs1_data", 64'(bus.rs1_data_o), 0);
        check("rst_out_rd", 64'(bus.out_rd_o), 0);
        check("rst_in_ready", 64'(bus.in_ready_o), 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        instr(1, 2, 3, 1, 5, 7);
        #1;
        check("t1_ready", 64'(bus.in_ready_o), 1);
        check("t1_rf_a1", 64'(bus.rf_a1_o), 1);
        check("t1_rf_a2", 64'(bus.rf_a2_o), 2);
        tick();
        idle();
        check("t1_valid", 64'(bus.out_valid_o), 1);
        check("t1_rs1", 64'(bus.rs1_data_o), 5);
        check("t1_rs2", 64'(bus.rs2_data_o), 7);
        check("t1_rd", 64'(bus.out_rd_o), 3);
        check("t1_rd_we", 64'(bus.out_rd_we_o), 1);
        check("t1_pend3", 64'(dut.pending[3]), 1);
        check("t1_inflight", 64'(dut.inflight), 1);
        instr(3, 0, 4, 1, 99, 55);
        #1;
        check("t2_raw_stall", 64'(bus.in_ready_o), 0);
        bus.wb_valid_i = 1;
        bus.wb_rd_i    = 3;
        bus.wb_data_i  = 12;
        #1;
        check("t2_stall_wb_cycle", 64'(bus.in_ready_o), 0);
        tick();
        bus.wb_valid_i = 0;
        bus.rf_rd1_i   = 12;
        #1;
        check("t2_release", 64'(bus.in_ready_o), 1);
        tick();
        idle();
        check("t2_rs1", 64'(bus.rs1_data_o), 12);
        check("t2_rs2_x0", 64'(bus.rs2_data_o), 0);
        check("t2_rd", 64'(bus.out_rd_o), 4);
        check("t2_inflight", 64'(dut.inflight), 2);
        do_reset();
        check("rst2_inflight", 64'(dut.inflight), 0);
        check("rst2_pending", 64'(dut.pending), 0);
        instr(6, 0, 7, 1, 32'h1111, 32'h2222);
        bus.wb_valid_i = 1;
        bus.wb_rd_i    = 6;
        bus.wb_data_i  = 32'hDEAD;
        tick();
        idle();
        check("t3_bypass", 64'(bus.rs1_data_o), 32'hDEAD);
        check("t3_x0", 64'(bus.rs2_data_o), 0);
        check("t3_pend7", 64'(dut.pending[7]), 1);
        check("t3_pend6", 64'(dut.pending[6]), 0);
        do_reset();
        instr(0, 0, 0, 1, 1, 1);
        tick();
        idle();
        check("t3_rd0_nopend", 64'(dut.pending), 0);
        do_reset();
        bus.out_ready_i = 0;
        instr(1, 2, 5, 1, 32'hA, 32'hB);
        tick();
        instr(8, 9, 10, 1, 32'hC, 32'hD);
        bus.out_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_bp_ready", 64'(bus.in_ready_o), 0);
            check("t4_bp_valid", 64'(bus.out_valid_o), 1);
            check("t4_bp_rs1", 64'(bus.rs1_data_o), 32'hA);
            check("t4_bp_rd", 64'(bus.out_rd_o), 5);
            tick();
        end
        bus.out_ready_i = 1;
        #1;
        check("t4_ready", 64'(bus.in_ready_o), 1);
        tick();
        idle();
        check("t4_valid", 64'(bus.out_valid_o), 1);
        check("t4_rs1", 64'(bus.rs1_data_o), 32'hC);
        check("t4_rs2", 64'(bus.rs2_data_o), 32'hD);
        check("t4_rd", 64'(bus.out_rd_o), 10);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            instr(0, 0, 11 + i, 1, 0, 0);
            #1;
            check("t5_fill_ready", 64'(bus.in_ready_o), 1);
            tick();
        end
        instr(0, 0, 15, 1, 0, 0);
        #1;
        check("t5_full_inflight", 64'(dut.inflight), 4);
        check("t5_full_ready", 64'(bus.in_ready_o), 0);
        bus.retire_i = 1;
        #1;
        check("t5_retire_ready", 64'(bus.in_ready_o), 1);
        tick();
        idle();
        check("t5_inflight", 64'(dut.inflight), 4);
        check("t5_rd", 64'(bus.out_rd_o), 15);
        do_reset();
        bus.out_ready_i = 0;
        instr(0, 0, 9, 1, 0, 0);
        tick();
        idle();
        bus.out_ready_i = 0;
        check("t6_pend9", 64'(dut.pending[9]), 1);
        bus.flush_i     = 1;
        bus.out_ready_i = 1;
        instr(0, 0, 1, 0, 0, 0);
        #1;
        check("t6_flush_block", 64'(bus.in_ready_o), 0);
        tick();
        idle();
        check("t6_valid", 64'(bus.out_valid_o), 0);
        check("t6_pend9_clr", 64'(dut.pending[9]), 0);
        check("t6_inflight", 64'(dut.inflight), 0);
        bus.out_ready_i = 0;
        instr(1, 0, 20, 1, 32'h77, 0);
        tick();
        instr(20, 0, 21, 1, 0, 0);
        bus.out_ready_i = 0;
        #1;
        check("t6_stall", 64'(bus.in_ready_o), 0);
        check("t6_rs1_held", 64'(bus.rs1_data_o), 32'h77);
        rst_n = 0;
        #1;
        check("t6_arst_valid", 64'(bus.out_valid_o), 0);
        check("t6_arst_rs1", 64'(bus.rs1_data_o), 0);
        check("t6_arst_rd", 64'(bus.out_rd_o), 0);
        check("t6_arst_we", 64'(bus.out_rd_we_o), 0);
        check("t6_arst_pending", 64'(dut.pending), 0);
        check("t6_arst_inflight", 64'(dut.inflight), 0);
        #10;
        rst_n = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_read_scoreboard.md
Name: rf_read_scoreboard

Overview:
- Decode-side reader for the integer register file.
- Accepts decoded instructions, presents rs1/rs2 addresses to the register file read ports, and bypasses same-cycle writeback data.
- Blocks issue on RAW/WAW hazards using a per-register pending scoreboard.
- Holds operands in a one-entry output register handed to execute through a valid/ready handshake.

Parameters:
- XLEN, 32, data width of operands and writeback data
- NREG, 32, number of architectural registers (address width = $clog2(NREG))
- MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions (counter width = $clog2(MAX_INFLIGHT+1))

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  decoded instruction present
- in_ready_o  out  1  issue accepted this cycle when in_valid_i && in_ready_o
- rs1_i, rs2_i, rd_i  in  5  source/destination register addresses
- rd_we_i  in  1  instruction writes rd
- rf_a1_o, rf_a2_o  out  5  register file read addresses (combinational = rs1_i, rs2_i)
- rf_rd1_i, rf_rd2_i  in  XLEN  register file read data (combinational)
- wb_valid_i  in  1  writeback of wb_data_i to wb_rd_i this cycle
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  XLEN  writeback data
- retire_i  in  1  one previously issued instruction retires (any type)
- flush_i  in  1  discard the held output entry, block issue this cycle
- out_valid_o  out  1  operand register valid
- out_ready_i  in  1  execute accepts operands
- rs1_data_o, rs2_data_o  out  XLEN  registered operands
- out_rd_o  out  5  registered destination
- out_rd_we_o  out  1  registered write enable

Behaviour:
- Reset (async, rst_n=0): pending[NREG-1:0]=0, inflight=0, out_valid_o=0, rs1_data_o=rs2_data_o=0, out_rd_o=0, out_rd_we_o=0. in_ready_o follows its equation from these values.
- x0: never pending. Operand reads of x0 return 0 regardless of rf_rd*_i or writeback. rd_we with rd=0 sets no pending bit.
- Hazard (uses registered pending): haz = pending[rs1] || pending[rs2] || (rd_we_i && pending[rd_i]), with x0 terms masked.
- in_ready_o = !flush_i && !haz && (!out_valid_o || out_ready_i) && (inflight < MAX_INFLIGHT || retire_i).
- Issue fire: next-cycle out_valid_o=1. Operands latched as follows:
  - operand = 0 if address is x0;
  - else wb_data_i if wb_valid_i && wb_rd_i == address (bypass);
  - else rf_rd*_i.
  - out_rd_o/out_rd_we_o latched from rd_i/rd_we_i.
  - pending[rd_i] set if rd_we_i && rd_i != 0.
- Output handoff: out_valid_o && out_ready_i without a new issue gives out_valid_o=0 next cycle. The entry holds stable while out_ready_i=0.
- Writeback: wb_valid_i clears pending[wb_rd_i]. A stall caused by a pending bit releases the cycle after the writeback (registered pending); the writeback data is taken from the register file then.
- Issue set and writeback clear never target the same register in one cycle, because WAW blocks the issue. If they would, set wins.
- inflight: +1 on issue, -1 on retire_i, unchanged when both occur. Retire at inflight=0 is ignored (no underflow).
- flush_i:
  - blocks issue;
  - clears out_valid_o;
  - if out_valid_o && out_rd_we_o && out_rd_o != 0, clears pending[out_rd_o] and decrements inflight;
  - takes priority over out_ready_i in the same cycle.
- Mid-operation reset: all pending, inflight and output state return to reset values immediately. No partial entry survives.

Test Plan:
- Reset then issue add x3,x1,x2 with rf_rd1=5, rf_rd2=7 -> next cycle out_valid=1, rs1_data=5, rs2_data=7, out_rd=3, pending[3]=1, inflight=1.
- Issue x4=x3+x0 while pending[3] -> in_ready=0. Apply wb_valid, wb_rd=3, wb_data=12 -> in_ready=1 the following cycle; rs1_data=12 (from rf), rs2_data=0.
- Same-cycle bypass: pending clear, wb_valid wb_rd=6 wb_data=0xDEAD, rf_rd1=0x1111, issue rs1=6 -> rs1_data_o=0xDEAD.
- Backpressure: out_ready=0 for 3 cycles after issue -> in_ready=0, outputs stable. out_ready=1 with a valid next instruction -> new entry loaded in one cycle without a bubble.
- Issue 4 instructions without retire -> in_ready=0 (inflight=4). Assert retire_i with a 5th valid instruction -> issues that cycle, inflight stays 4.
- flush_i with held entry rd=9 (pending) -> out_valid=0, pending[9]=0 next cycle. Assert rst_n=0 mid-stall -> all outputs 0 asynchronously.
